// File: rtl/uart_tx_framed_if.sv
// Word handshake into the framed UART transmitter: data is taken on any edge
// where valid and ready are both high.
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: one-entry holding register feeding a start/data/parity/stop shifter.
// The start bit leaves one edge after the handshake; ready drops while the holding register is full.
module uart_tx_framed #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 104
) (
    input  logic            clk,
    input  logic            rstn,
    uart_tx_framed_if.slave bus,
    output logic            tx,
    output logic            busy
);
    localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS);
    localparam logic [3:0]    FRAME_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 hold_full_q;
    logic                 hold_full_d;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [BW-1:0]        baud_q;
    logic [3:0]           bit_q;

    logic accept;
    logic baud_wrap;
    logic frame_end;
    logic load;

    always_comb begin
        accept    = bus.valid && !hold_full_q;
        baud_wrap = (baud_q == BAUD_LAST);
        frame_end = (state_q == S_STOP) && baud_wrap && (bit_q == FRAME_LAST);
        // A pending word starts either from idle or straight after the final stop bit.
        load      = hold_full_q && ((state_q == S_IDLE) || frame_end);
        hold_full_d = hold_full_q;
        if (load)
            hold_full_d = 1'b0;
        if (accept)
            hold_full_d = 1'b1;
    end

    assign bus.ready = !hold_full_q;
    assign tx        = tx_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            if (accept)
                hold_q <= bus.data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (load) begin
            state_q <= S_START;
            shift_q <= hold_q;
            par_q   <= (^hold_q) ^ (PARITY == 1);
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else if (state_q != S_IDLE) begin
            if (!baud_wrap) begin
                baud_q <= baud_q + 1'b1;
            end else begin
                baud_q <= '0;
                bit_q  <= bit_q + 4'd1;
                // bit_q names the bit currently on the line: 0 is start, DATA_LAST the last data bit.
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    S_DATA: begin
                        if (bit_q == DATA_LAST) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                    S_STOP: begin
                        if (bit_q == FRAME_LAST) begin
                            state_q <= S_IDLE;
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter BAUD_DIV, default 104, meaning clk cycles per serial bit (12 MHz / 115200); legal range >= 2.
REQ-005 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data, input, DATA_BITS, word to transmit; sampled only on an accepted handshake.
REQ-008 SHALL have port valid, input, 1, producer asserts when data holds a word to send.
REQ-009 SHALL have port ready, output, 1, high when the holding register is empty and can accept a word.
REQ-010 SHALL have port tx, output, 1, registered serial line; idle level 1.
REQ-011 SHALL have port busy, output, 1, high from the first cycle of a start bit to the last cycle of the final stop bit.

Function
REQ-012 SHALL accept a word on a rising clk edge where valid=1 and ready=1; data is copied into a one-entry holding register and ready falls on that same edge.
REQ-013 SHALL ignore valid while ready=0; no word is lost, overwritten or duplicated.
REQ-014 SHALL use frame format: start bit 0, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits of value 1.
REQ-015 SHALL set parity bit to XOR of data bits for even mode, and to its inverse for odd mode; no parity bit is sent in mode 0.
REQ-016 SHALL hold every bit on tx for exactly BAUD_DIV clk cycles; frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
REQ-017 SHALL run the controller as IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE, or STOP -> START when the holding register is full.
REQ-018 SHALL, in IDLE with holding register full, load the shifter and empty the holding register on the next edge; tx goes 0 one edge after the handshake edge.
REQ-019 SHALL raise ready on the edge the holding register transfers to the shifter, so the next word can be accepted while the current frame is in flight.
REQ-020 SHALL restart the baud counter at 0 at every frame start; the counter runs 0..BAUD_DIV-1 and stays at 0 in IDLE.
REQ-021 SHALL use a bit counter wide enough for 13 bits; it clears at frame start and increments on each baud counter wrap.
REQ-022 SHALL, when a word is pending at the last cycle of the final stop bit, start the next start bit on the following cycle with zero idle cycles between frames.
REQ-023 SHALL, when a handshake and a holding-to-shifter transfer occur on the same edge, keep the new word in the holding register and leave ready=0.
REQ-024 SHALL keep tx=1 and busy=0 in IDLE.

Reset
REQ-025 SHALL, on rstn=0 at any time including mid-frame, immediately force tx=1, busy=0, ready=1, state IDLE, holding register empty, and both counters to 0.
REQ-026 SHALL accept a handshake on the first rising clk edge after rstn deasserts.

Verification
REQ-027 SHALL pass this case with DATA_BITS=8, PARITY=0, STOP_BITS=1, BAUD_DIV=4: send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit, 40 cycles total, then busy=0.
REQ-028 SHALL pass this case with PARITY=2, send 0x07 -> parity bit 1; with PARITY=1, send 0x07 -> parity bit 0; frame is 44 cycles at BAUD_DIV=4.
REQ-029 SHALL pass this case: present 0xA3 then 0x3C back-to-back with valid held high -> second start bit begins on cycle 40 of the first frame with no idle gap, busy stays 1 for 80 cycles, and ready rises once per transfer.
REQ-030 SHALL pass this case: hold valid=1 for 100 cycles with a single fixed word while ready=0 -> exactly the number of frames equal to the accepted handshakes, no duplicates.
REQ-031 SHALL pass this case: drop rstn to 0 at cycle 17 of a frame -> tx=1 and ready=1 before the next clk edge, with no partial frame resumed after release.
REQ-032 SHALL pass this case with DATA_BITS=5 and STOP_BITS=2, send 0x1F -> tx = 0,1,1,1,1,1,1,1, frame length 8*BAUD_DIV cycles.
